// File: rtl/circuito_jogo_param_pkg.sv
// rtl/circuito_jogo_param_pkg.sv - shared state codes, mode encodings and target helper for the memory game
//
// Purpose: FSM state encoding (5-bit, visible on db_estado), difficulty mode
// encodings and the helper that maps a mode to the index of the final round.
package circuito_jogo_param_pkg;

  typedef enum logic [4:0] {
    INICIAL          = 5'h00,
    PREPARACAO       = 5'h01,
    ESPERA_SEMENTE   = 5'h02,
    REGISTRA_SEMENTE = 5'h03,
    PROXIMA_RODADA   = 5'h04,
    ESPERA_JOGADA    = 5'h05,
    COMPARA          = 5'h06,
    ESPERA_NOVA      = 5'h07,
    SALVA            = 5'h08,
    FIM_GANHOU       = 5'h1C,
    FIM_PERDEU       = 5'h1D,
    FIM_TIMEOUT      = 5'h1E
  } estado_t;

  localparam logic MODO_CURTO = 1'b0;  // target = MAX_RODADAS/2 moves
  localparam logic MODO_LONGO = 1'b1;  // target = MAX_RODADAS moves

  // Index of the last round (T-1) for the given mode.
  function automatic int indice_final(input logic m, input int max_rodadas);
    return (m == MODO_LONGO) ? max_rodadas - 1 : max_rodadas / 2 - 1;
  endfunction

endpackage

// File: rtl/circuito_jogo_param_ram_jogadas.sv
// rtl/circuito_jogo_param_ram_jogadas.sv - single-port move sequence memory
//
// Purpose: stores the move sequence; synchronous write, asynchronous read.
// Contents are not reset (never read before being written by the game).
// Ports:
//   clock  in  1          write clock
//   we     in  1          write enable
//   addr   in  ADDR_W     shared read/write address
//   wdata  in  N_BOTOES   move to store
//   rdata  out N_BOTOES   move at addr (combinational)
module ram_jogadas #(
  parameter  int N_BOTOES    = 4,
  parameter  int MAX_RODADAS = 16,
  localparam int ADDR_W      = $clog2(MAX_RODADAS)
) (
  input  logic                clock,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [N_BOTOES-1:0] wdata,
  output logic [N_BOTOES-1:0] rdata
);

  logic [N_BOTOES-1:0] mem [MAX_RODADAS];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/circuito_jogo_param.sv
// rtl/circuito_jogo_param.sv - parametrised memory-game datapath and FSM
//
// Purpose: player enters a seed move, then each round repeats the stored
// sequence and appends one new move, until the target length is reached
// (win), a wrong/invalid move is entered or the idle timeout expires (loss).
// Ports:
//   clock, reset           clock, asynchronous active-high reset
//   jogar                  start request (only honoured in inicial / fim_*)
//   modo                   0: short target, 1: full target; latched on start
//   botoes                 one-hot button inputs
//   leds                   last captured move, all-ones after a win
//   ganhou, perdeu, pronto game result flags
//   db_estado, db_rodada, db_contagem, db_igual, db_tem_jogada, db_timeout
//                          debug visibility of FSM and datapath
module circuito_jogo_param
  import circuito_jogo_param_pkg::*;
#(
  parameter  int N_BOTOES       = 4,
  parameter  int MAX_RODADAS    = 16,
  parameter  int TIMEOUT_CICLOS = 3000,
  localparam int ADDR_W         = $clog2(MAX_RODADAS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                jogar,
  input  logic                modo,
  input  logic [N_BOTOES-1:0] botoes,
  output logic [N_BOTOES-1:0] leds,
  output logic                ganhou,
  output logic                perdeu,
  output logic                pronto,
  output logic [4:0]          db_estado,
  output logic [ADDR_W-1:0]   db_rodada,
  output logic [ADDR_W-1:0]   db_contagem,
  output logic                db_igual,
  output logic                db_tem_jogada,
  output logic                db_timeout
);

  localparam int TMR_W = $clog2(TIMEOUT_CICLOS);
  localparam logic [TMR_W-1:0] TMR_FIM = TMR_W'(TIMEOUT_CICLOS - 1);

  estado_t             estado;
  logic                tem_jogada_q;
  logic [N_BOTOES-1:0] jogada;
  logic [ADDR_W-1:0]   rodada;
  logic [ADDR_W-1:0]   contagem;
  logic [TMR_W-1:0]    tmr;
  logic                modo_q;

  logic                tem_jogada;
  logic                evento;
  logic                em_espera;
  logic                timeout_fim;
  logic                jogada_valida;
  logic                igual;
  logic [ADDR_W-1:0]   ultima_rodada;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_addr;
  logic [N_BOTOES-1:0] ram_rdata;

  // Rising edge of "any button" is the press event; holding gives one event.
  assign tem_jogada = |botoes;
  assign evento     = tem_jogada & ~tem_jogada_q;

  assign em_espera   = (estado == ESPERA_SEMENTE) || (estado == ESPERA_JOGADA) ||
                       (estado == ESPERA_NOVA);
  assign timeout_fim = (tmr == TMR_FIM);

  // Zero or multiple bits set can never match a stored move.
  assign jogada_valida = (jogada != '0) &&
                         ((jogada & (jogada - N_BOTOES'(1))) == '0);
  assign igual         = jogada_valida && (jogada == ram_rdata);

  assign ultima_rodada = ADDR_W'(indice_final(modo_q, MAX_RODADAS));

  // RAM is written only in the two storing states; otherwise it is read at
  // the current position in the round.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = contagem;
    if (estado == REGISTRA_SEMENTE) begin
      ram_we   = 1'b1;
      ram_addr = '0;
    end else if (estado == SALVA) begin
      ram_we   = 1'b1;
      ram_addr = rodada + ADDR_W'(1);
    end
  end

  ram_jogadas #(
    .N_BOTOES    (N_BOTOES),
    .MAX_RODADAS (MAX_RODADAS)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (jogada),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado       <= INICIAL;
      tem_jogada_q <= 1'b0;
      jogada       <= '0;
      rodada       <= '0;
      contagem     <= '0;
      tmr          <= '0;
      modo_q       <= MODO_CURTO;
      leds         <= '0;
      ganhou       <= 1'b0;
      perdeu       <= 1'b0;
      pronto       <= 1'b0;
      db_igual     <= 1'b0;
      db_timeout   <= 1'b0;
    end else begin
      tem_jogada_q <= tem_jogada;

      // Idle timer: counts only while waiting; any press or exit clears it.
      if (em_espera && !evento && !timeout_fim) tmr <= tmr + TMR_W'(1);
      else                                      tmr <= '0;

      if (em_espera && evento) begin
        jogada <= botoes;
        leds   <= botoes;
      end

      unique case (estado)
        INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: begin
          if (jogar) begin
            estado     <= PREPARACAO;
            leds       <= '0;
            jogada     <= '0;
            ganhou     <= 1'b0;
            perdeu     <= 1'b0;
            pronto     <= 1'b0;
            db_igual   <= 1'b0;
            db_timeout <= 1'b0;
          end
        end
        PREPARACAO: begin
          rodada   <= '0;
          contagem <= '0;
          modo_q   <= modo;
          estado   <= ESPERA_SEMENTE;
        end
        ESPERA_SEMENTE, ESPERA_JOGADA, ESPERA_NOVA: begin
          // A press on the terminal count still wins over the timeout.
          if (evento) begin
            case (estado)
              ESPERA_SEMENTE: estado <= REGISTRA_SEMENTE;
              ESPERA_JOGADA:  estado <= COMPARA;
              default:        estado <= SALVA;
            endcase
          end else if (timeout_fim) begin
            estado     <= FIM_TIMEOUT;
            perdeu     <= 1'b1;
            pronto     <= 1'b1;
            db_timeout <= 1'b1;
          end
        end
        REGISTRA_SEMENTE: estado <= PROXIMA_RODADA;
        PROXIMA_RODADA: begin
          contagem <= '0;
          estado   <= ESPERA_JOGADA;
        end
        COMPARA: begin
          db_igual <= igual;
          if (!igual) begin
            estado <= FIM_PERDEU;
            perdeu <= 1'b1;
            pronto <= 1'b1;
          end else if (contagem != rodada) begin
            contagem <= contagem + ADDR_W'(1);
            estado   <= ESPERA_JOGADA;
          end else if (rodada == ultima_rodada) begin
            estado <= FIM_GANHOU;
            ganhou <= 1'b1;
            pronto <= 1'b1;
            leds   <= '1;
          end else begin
            estado <= ESPERA_NOVA;
          end
        end
        SALVA: begin
          rodada   <= rodada + ADDR_W'(1);
          contagem <= '0;
          estado   <= ESPERA_JOGADA;
        end
        default: estado <= INICIAL;
      endcase
    end
  end

  assign db_estado     = estado;
  assign db_rodada     = rodada;
  assign db_contagem   = contagem;
  assign db_tem_jogada = tem_jogada;

endmodule

// File: tb/tb_circuito_jogo_param.sv
// tb/tb_circuito_jogo_param.sv - self-checking bench for circuito_jogo_param
module tb_circuito_jogo_param;
  import circuito_jogo_param_pkg::*;

  localparam int NB = 4;
  localparam int MR = 8;
  localparam int TO = 100;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          jogar = 1'b0;
  logic          modo  = 1'b0;
  logic [NB-1:0] botoes = '0;
  logic [NB-1:0] leds;
  logic          ganhou, perdeu, pronto;
  logic [4:0]    db_estado;
  logic [2:0]    db_rodada, db_contagem;
  logic          db_igual, db_tem_jogada, db_timeout;

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] seq [MR];

  circuito_jogo_param #(.N_BOTOES(NB), .MAX_RODADAS(MR), .TIMEOUT_CICLOS(TO)) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .modo(modo), .botoes(botoes),
    .leds(leds), .ganhou(ganhou), .perdeu(perdeu), .pronto(pronto),
    .db_estado(db_estado), .db_rodada(db_rodada), .db_contagem(db_contagem),
    .db_igual(db_igual), .db_tem_jogada(db_tem_jogada), .db_timeout(db_timeout)
  );

  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_leds"}, leds, 0);
    check({tag, "_ganhou"}, ganhou, 0);
    check({tag, "_perdeu"}, perdeu, 0);
    check({tag, "_pronto"}, pronto, 0);
    check({tag, "_estado"}, db_estado, INICIAL);
    check({tag, "_rodada"}, db_rodada, 0);
    check({tag, "_contagem"}, db_contagem, 0);
    check({tag, "_igual"}, db_igual, 0);
    check({tag, "_tem_jogada"}, db_tem_jogada, 0);
    check({tag, "_timeout"}, db_timeout, 0);
  endtask

  task automatic hold(input logic [3:0] v, input int n);
    @(negedge clock); botoes = v;
    @(negedge clock); check("tem_jogada", db_tem_jogada, {31'b0, |v});
    repeat (n - 1) @(negedge clock);
    botoes = '0;
    repeat (10) @(negedge clock);
  endtask

  task automatic press(input logic [3:0] v);
    hold(v, 10);
  endtask

  task automatic start_game(input logic m);
    @(negedge clock); modo = m; jogar = 1'b1;
    @(negedge clock); jogar = 1'b0;
    check("start_estado", db_estado, PREPARACAO);
    check("start_perdeu", perdeu, 0);
    check("start_ganhou", ganhou, 0);
    check("start_pronto", pronto, 0);
    check("start_leds", leds, 0);
    check("start_timeout", db_timeout, 0);
  endtask

  // Enters the seed and returns on the first cycle spent in espera_jogada.
  task automatic seed_and_sync(input logic [3:0] v);
    @(negedge clock); botoes = v;
    repeat (2) @(negedge clock);
    botoes = '0;
    for (int i = 0; i < 20 && db_estado !== ESPERA_JOGADA; i++) @(negedge clock);
    check("sync_espera", db_estado, ESPERA_JOGADA);
  endtask

  // Plays the game in seq[] by the rules; when (stop_r, stop_p) is reached
  // the move 'bad' is entered instead of the stored one.
  task automatic play_game(input logic m, input int stop_r, input int stop_p,
                           input logic [3:0] bad, input bit pulse);
    int t;
    t = (m == MODO_LONGO) ? MR : MR / 2;
    start_game(m);
    press(seq[0]);
    if (pulse) begin
      @(negedge clock); jogar = 1'b1; modo = ~m;
      @(negedge clock); jogar = 1'b0;
      @(negedge clock);
      check("jogar_ignored", db_estado, ESPERA_JOGADA);
    end
    for (int r = 0; r < t; r++) begin
      for (int p = 0; p <= r; p++) begin
        if (r == stop_r && p == stop_p) begin
          press(bad);
          return;
        end
        press(seq[p]);
        if (p < r) check("contagem", db_contagem, p + 1);
      end
      if (r == t - 1) return;
      press(seq[r + 1]);
      check("rodada", db_rodada, r + 1);
      check("contagem0", db_contagem, 0);
    end
  endtask

  task automatic check_end(input logic m, input int stop_r, input int stop_p,
                           input logic [3:0] bad);
    int t;
    t = (m == MODO_LONGO) ? MR : MR / 2;
    if (stop_r >= 0) begin
      check("lose_perdeu", perdeu, 1);
      check("lose_ganhou", ganhou, 0);
      check("lose_pronto", pronto, 1);
      check("lose_timeout", db_timeout, 0);
      check("lose_igual", db_igual, 0);
      check("lose_rodada", db_rodada, stop_r);
      check("lose_contagem", db_contagem, stop_p);
      check("lose_leds", leds, bad);
      check("lose_estado", db_estado, FIM_PERDEU);
    end else begin
      check("win_ganhou", ganhou, 1);
      check("win_perdeu", perdeu, 0);
      check("win_pronto", pronto, 1);
      check("win_leds", leds, 4'hF);
      check("win_rodada", db_rodada, t - 1);
      check("win_contagem", db_contagem, t - 1);
      check("win_igual", db_igual, 1);
      check("win_estado", db_estado, FIM_GANHOU);
    end
  endtask

  function automatic logic [3:0] rand_move();
    return 4'b0001 << $urandom_range(0, NB - 1);
  endfunction

  initial begin
    logic       m;
    int         sr, sp, t;
    logic [3:0] bad;

    // Reset state
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clock);

    // Short mode, fixed sequence, with a mid-game jogar pulse: win
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000;
    play_game(MODO_CURTO, -1, -1, 4'b0, 1'b1);
    check_end(MODO_CURTO, -1, -1, 4'b0);

    // Long mode, wrong second press in round 1: loss
    seq[0] = 4'b0001; seq[1] = 4'b0010;
    for (int i = 2; i < MR; i++) seq[i] = rand_move();
    play_game(MODO_LONGO, 1, 1, 4'b1000, 1'b0);
    check_end(MODO_LONGO, 1, 1, 4'b1000);

    // Restart from fim_perdeu and win a new random short game
    for (int i = 0; i < MR; i++) seq[i] = rand_move();
    play_game(MODO_CURTO, -1, -1, 4'b0, 1'b1);
    check_end(MODO_CURTO, -1, -1, 4'b0);

    // Long hold gives one event; invalid move loses
    start_game(MODO_LONGO);
    press(4'b0001);
    press(4'b0001);
    press(4'b0010);
    check("hold_rodada", db_rodada, 1);
    hold(4'b0001, 50);
    check("hold_contagem", db_contagem, 1);
    check("hold_estado", db_estado, ESPERA_JOGADA);
    check("hold_igual", db_igual, 1);
    press(4'b0011);
    check("invalid_igual", db_igual, 0);
    check("invalid_perdeu", perdeu, 1);
    check("invalid_contagem", db_contagem, 1);

    // Idle exactly TO clocks in espera_jogada: timeout
    start_game(MODO_CURTO);
    seed_and_sync(4'b0100);
    repeat (TO - 1) @(negedge clock);
    check("to_before_estado", db_estado, ESPERA_JOGADA);
    check("to_before_perdeu", perdeu, 0);
    @(negedge clock);
    check("to_estado", db_estado, FIM_TIMEOUT);
    check("to_perdeu", perdeu, 1);
    check("to_flag", db_timeout, 1);
    check("to_pronto", pronto, 1);
    check("to_ganhou", ganhou, 0);

    // Press on the last allowed clock wins over the timeout
    start_game(MODO_CURTO);
    seed_and_sync(4'b0100);
    repeat (TO - 1) @(negedge clock);
    botoes = 4'b0100;
    @(negedge clock);
    check("late_compara", db_estado, COMPARA);
    @(negedge clock);
    check("late_estado", db_estado, ESPERA_NOVA);
    check("late_timeout", db_timeout, 0);
    check("late_perdeu", perdeu, 0);
    check("late_igual", db_igual, 1);
    botoes = '0;
    repeat (TO + 10) @(negedge clock);
    check("nova_timeout", db_estado, FIM_TIMEOUT);
    check("nova_timeout_flag", db_timeout, 1);

    // Random games checked against the rules
    for (int g = 0; g < 4; g++) begin
      m = 1'($urandom_range(0, 1));
      t = (m == MODO_LONGO) ? MR : MR / 2;
      for (int i = 0; i < MR; i++) seq[i] = rand_move();
      sr = -1; sp = -1; bad = '0;
      if ($urandom_range(0, 1) == 1) begin
        sr  = $urandom_range(0, t - 1);
        sp  = $urandom_range(0, sr);
        bad = 4'($urandom_range(1, 15));
        if (bad == seq[sp]) bad = bad ^ 4'b0011;
      end
      play_game(m, sr, sp, bad, g[0]);
      check_end(m, sr, sp, bad);
    end

    // Asynchronous reset in espera_nova at round 2
    for (int i = 0; i < MR; i++) seq[i] = rand_move();
    start_game(MODO_LONGO);
    press(seq[0]);
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p <= r; p++) press(seq[p]);
      if (r < 2) press(seq[r + 1]);
    end
    check("pre_reset_estado", db_estado, ESPERA_NOVA);
    check("pre_reset_rodada", db_rodada, 2);
    @(negedge clock);
    #2 reset = 1'b1;
    #1 check_zero("async_reset");
    repeat (2) @(negedge clock);
    check("reset_held_estado", db_estado, INICIAL);
    reset = 1'b0;
    @(negedge clock);
    check("after_reset_estado", db_estado, INICIAL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
